mem_arbiter: RTL

Arbiter and sequencer that shares the single memory-controller request port between the instruction-fetch path and the load/store buffer. It sits between the fetch unit / LSB and the byte-serial memory controller. It grants one requester at a time and holds the granted request stable until the controller completes. It squashes fetches on branch rollback, guards fetch against starvation, and withholds IO stores while the UART buffer is full.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-port arbiter.
//   - arb_state_e : arbiter sequencer states
//   - size_e      : access size encodings on the *Bits fields
//   - IO_HI       : addr[17:16] value that selects the IO region
//   - is_io()     : true when an address falls in the IO region
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_L = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_e;

    localparam logic [1:0] IO_HI = 2'b11;

    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == IO_HI;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch unit, the load/store buffer,
// the arbiter and the memory controller.
//   fetch side : iFlag, iAddr -> iDone, iData
//   LSB side   : lsbFlag, lsbWrite, lsbBits, lsbAddr, lsbData -> lsbDone, lsbLoaded
//   controller : mcFlag, mcWrite, mcBits, mcAddr, mcData -> mcDone, mcLoaded
// Modport slave is the arbiter's view; master is the view of the requesters
// and controller that surround it.
interface mem_arbiter_if;

    logic        iFlag;
    logic [31:0] iAddr;
    logic        iDone;
    logic [31:0] iData;

    logic        lsbFlag;
    logic        lsbWrite;
    logic [1:0]  lsbBits;
    logic [31:0] lsbAddr;
    logic [31:0] lsbData;
    logic        lsbDone;
    logic [31:0] lsbLoaded;

    logic        mcFlag;
    logic        mcWrite;
    logic [1:0]  mcBits;
    logic [31:0] mcAddr;
    logic [31:0] mcData;
    logic        mcDone;
    logic [31:0] mcLoaded;

    modport slave (
        input  iFlag, iAddr, lsbFlag, lsbWrite, lsbBits, lsbAddr, lsbData,
               mcDone, mcLoaded,
        output iDone, iData, lsbDone, lsbLoaded,
               mcFlag, mcWrite, mcBits, mcAddr, mcData
    );

    modport master (
        output iFlag, iAddr, lsbFlag, lsbWrite, lsbBits, lsbAddr, lsbData,
               mcDone, mcLoaded,
        input  iDone, iData, lsbDone, lsbLoaded,
               mcFlag, mcWrite, mcBits, mcAddr, mcData
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single memory-controller request port between instruction fetch
// and the load/store buffer. One grant at a time; the granted request is held
// on mc* until mcDone, then the requester gets a one-cycle Done pulse.
// Fetches can be squashed by rollback, fetch is protected from starvation,
// and IO stores are withheld while the UART buffer is full.
// Ports:
//   clkIn          : clock
//   rstIn          : synchronous active-high reset
//   rdyIn          : global stall, low freezes everything
//   rollback       : branch mispredict pulse
//   io_buffer_full : UART buffer full
//   bus            : request/response bundle (slave view)
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clkIn,
    input  logic          rstIn,
    input  logic          rdyIn,
    input  logic          rollback,
    input  logic          io_buffer_full,
    mem_arbiter_if.slave  bus
);

    arb_state_e  state_q, state_d;
    logic        squash_q, squash_d;
    logic [3:0]  starve_q, starve_d;

    logic        mc_flag_q, mc_flag_d;
    logic        mc_write_q, mc_write_d;
    logic [1:0]  mc_bits_q, mc_bits_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic [31:0] mc_data_q, mc_data_d;

    logic        i_done_q, i_done_d;
    logic [31:0] i_data_q, i_data_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] lsb_loaded_q, lsb_loaded_d;

    logic lsb_ok, i_ok, pick_i, pick_l;

    // A store into the IO region must wait while the UART cannot take it.
    assign lsb_ok = bus.lsbFlag &&
                    !(bus.lsbWrite && is_io(bus.lsbAddr) && io_buffer_full);
    assign i_ok   = bus.iFlag && !rollback;
    // LSB normally wins; fetch wins once it has waited out STARVE_LIMIT grants.
    assign pick_i = i_ok && (!lsb_ok || (starve_q >= 4'(STARVE_LIMIT)));
    assign pick_l = lsb_ok && !pick_i;

    always_comb begin
        state_d      = state_q;
        squash_d     = squash_q;
        starve_d     = starve_q;
        mc_flag_d    = mc_flag_q;
        mc_write_d   = mc_write_q;
        mc_bits_d    = mc_bits_q;
        mc_addr_d    = mc_addr_q;
        mc_data_d    = mc_data_q;
        i_done_d     = 1'b0;
        i_data_d     = i_data_q;
        lsb_done_d   = 1'b0;
        lsb_loaded_d = lsb_loaded_q;

        unique case (state_q)
            IDLE: begin
                if (!bus.iFlag) starve_d = 4'd0;
                if (pick_i) begin
                    mc_flag_d  = 1'b1;
                    mc_write_d = 1'b0;
                    mc_bits_d  = WORD;
                    mc_addr_d  = bus.iAddr;
                    mc_data_d  = 32'd0;
                    starve_d   = 4'd0;
                    squash_d   = 1'b0;
                    state_d    = BUSY_I;
                end else if (pick_l) begin
                    mc_flag_d  = 1'b1;
                    mc_write_d = bus.lsbWrite;
                    mc_bits_d  = bus.lsbBits;
                    mc_addr_d  = bus.lsbAddr;
                    mc_data_d  = bus.lsbData;
                    if (bus.iFlag && starve_q != 4'd15) starve_d = starve_q + 4'd1;
                    state_d    = BUSY_L;
                end
            end
            BUSY_I: begin
                // The controller transfer cannot be aborted, so a rollback only
                // marks the result to be dropped when it eventually arrives.
                if (rollback) squash_d = 1'b1;
                if (bus.mcDone) begin
                    mc_flag_d = 1'b0;
                    if (squash_q || rollback) begin
                        squash_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        i_data_d = bus.mcLoaded;
                        i_done_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            BUSY_L: begin
                if (bus.mcDone) begin
                    mc_flag_d    = 1'b0;
                    lsb_loaded_d = bus.mcLoaded;
                    lsb_done_d   = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                // Requester drops its Flag this cycle, so no arbitration here.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q      <= IDLE;
            squash_q     <= 1'b0;
            starve_q     <= 4'd0;
            mc_flag_q    <= 1'b0;
            mc_write_q   <= 1'b0;
            mc_bits_q    <= 2'b00;
            mc_addr_q    <= 32'd0;
            mc_data_q    <= 32'd0;
            i_done_q     <= 1'b0;
            i_data_q     <= 32'd0;
            lsb_done_q   <= 1'b0;
            lsb_loaded_q <= 32'd0;
        end else if (rdyIn) begin
            state_q      <= state_d;
            squash_q     <= squash_d;
            starve_q     <= starve_d;
            mc_flag_q    <= mc_flag_d;
            mc_write_q   <= mc_write_d;
            mc_bits_q    <= mc_bits_d;
            mc_addr_q    <= mc_addr_d;
            mc_data_q    <= mc_data_d;
            i_done_q     <= i_done_d;
            i_data_q     <= i_data_d;
            lsb_done_q   <= lsb_done_d;
            lsb_loaded_q <= lsb_loaded_d;
        end
    end

    assign bus.mcFlag    = mc_flag_q;
    assign bus.mcWrite   = mc_write_q;
    assign bus.mcBits    = mc_bits_q;
    assign bus.mcAddr    = mc_addr_q;
    assign bus.mcData    = mc_data_q;
    assign bus.iDone     = i_done_q;
    assign bus.iData     = i_data_q;
    assign bus.lsbDone   = lsb_done_q;
    assign bus.lsbLoaded = lsb_loaded_q;

endmodule
